// File: rtl/mips_pkg.sv
// Shared constants and helpers for the fetch/decode instruction queue.
package mips_pkg;

    // Encoding presented to decode when a slot holds no real instruction.
    localparam logic [31:0] NOP_INSTR = 32'h0000_0000;

    // Default queue geometry.
    localparam int unsigned IQ_DEPTH = 8;
    localparam int unsigned IQ_PTR_W = $clog2(IQ_DEPTH);

    // Decode may report 0..2 consumed entries; the encoding 3 means 2.
    function automatic logic [1:0] clamp_deq(input logic [1:0] req);
        return (req == 2'd3) ? 2'd2 : req;
    endfunction

endpackage

// File: rtl/iq_storage.sv
// Register file for the instruction queue: each entry is {instr, pc}.
// Two write ports share one enable (a fetch pair always lands together),
// two asynchronous read ports feed the decode pair directly.
module iq_storage #(
    parameter int unsigned DEPTH = 8,
    parameter int unsigned WIDTH = 32,
    parameter int unsigned PTR_W = $clog2(DEPTH)
) (
    input  logic                 clk,
    input  logic                 i_we,
    input  logic [PTR_W-1:0]     i_waddr0,
    input  logic [PTR_W-1:0]     i_waddr1,
    input  logic [2*WIDTH-1:0]   i_wdata0,
    input  logic [2*WIDTH-1:0]   i_wdata1,
    input  logic [PTR_W-1:0]     i_raddr0,
    input  logic [PTR_W-1:0]     i_raddr1,
    output logic [2*WIDTH-1:0]   o_rdata0,
    output logic [2*WIDTH-1:0]   o_rdata1
);

    logic [2*WIDTH-1:0] r_mem [DEPTH];

    // Write both halves of a fetch pair; contents are never cleared, the
    // control logic's count decides which entries are meaningful.
    always_ff @(posedge clk) begin
        if (i_we) begin
            r_mem[i_waddr0] <= i_wdata0;
            r_mem[i_waddr1] <= i_wdata1;
        end
    end

    // Asynchronous reads so decode sees the head entries in the same cycle.
    assign o_rdata0 = r_mem[i_raddr0];
    assign o_rdata1 = r_mem[i_raddr1];

endmodule

// File: rtl/fetch_issue_queue.sv
// Instruction queue between a dual-issue fetch stage and a dual decoder.
// Fetch pushes aligned pairs, decode pops 0..2 per cycle in program order.
module fetch_issue_queue
    import mips_pkg::*;
#(
    parameter int unsigned DEPTH = IQ_DEPTH,
    parameter int unsigned WIDTH = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             fvalid,
    input  logic [WIDTH-1:0] instrf,
    input  logic [WIDTH-1:0] instrf2,
    input  logic [WIDTH-1:0] pcf,
    input  logic             flushd,
    input  logic [1:0]       deqcnt,
    output logic             stallf,
    output logic             validd,
    output logic             validd2,
    output logic [WIDTH-1:0] instrd,
    output logic [WIDTH-1:0] instrd2,
    output logic [WIDTH-1:0] pcd,
    output logic [WIDTH-1:0] pcd2,
    output logic [WIDTH-1:0] pcplus4d,
    output logic [WIDTH-1:0] pcplus4d2
);

    localparam int unsigned PTR_W = $clog2(DEPTH);
    localparam int unsigned CNT_W = PTR_W + 1;

    logic [PTR_W-1:0]   r_head;
    logic [PTR_W-1:0]   r_tail;
    logic [CNT_W-1:0]   r_count;

    logic               w_stall;
    logic               w_enq;
    logic [CNT_W-1:0]   w_deq_req;
    logic [CNT_W-1:0]   w_deq_n;
    logic [CNT_W-1:0]   w_count_next;
    logic [2*WIDTH-1:0] w_rdata0;
    logic [2*WIDTH-1:0] w_rdata1;
    logic [WIDTH-1:0]   w_pc0;
    logic [WIDTH-1:0]   w_pc1;

    // Stall looks only at the registered count so decode's consume signal
    // never reaches fetch combinationally; leaving two free slots is the price.
    assign w_stall = (r_count > CNT_W'(DEPTH - 2));
    assign w_enq   = fvalid && !w_stall && !flushd;

    // Pop request clamped to 2 and then to what is actually queued.
    assign w_deq_req    = CNT_W'(clamp_deq(deqcnt));
    assign w_deq_n      = (w_deq_req > r_count) ? r_count : w_deq_req;
    assign w_count_next = r_count + (w_enq ? CNT_W'(2) : CNT_W'(0)) - w_deq_n;

    // Pointer and occupancy update; a flush behaves exactly like reset and
    // swallows any enqueue or dequeue in the same cycle.
    always_ff @(posedge clk) begin
        if (reset || flushd) begin
            r_head  <= '0;
            r_tail  <= '0;
            r_count <= '0;
        end else begin
            r_head  <= r_head + PTR_W'(w_deq_n);
            r_count <= w_count_next;
            if (w_enq) begin
                r_tail <= r_tail + PTR_W'(2);
            end
        end
    end

    iq_storage #(
        .DEPTH (DEPTH),
        .WIDTH (WIDTH),
        .PTR_W (PTR_W)
    ) u_storage (
        .clk      (clk),
        .i_we     (w_enq),
        .i_waddr0 (r_tail),
        .i_waddr1 (r_tail + PTR_W'(1)),
        .i_wdata0 ({instrf,  pcf}),
        .i_wdata1 ({instrf2, pcf + WIDTH'(4)}),
        .i_raddr0 (r_head),
        .i_raddr1 (r_head + PTR_W'(1)),
        .o_rdata0 (w_rdata0),
        .o_rdata1 (w_rdata1)
    );

    assign w_pc0 = w_rdata0[WIDTH-1:0];
    assign w_pc1 = w_rdata1[WIDTH-1:0];

    // Decode-side outputs: stale storage is masked to NOP / zero PCs when
    // the slot is not occupied.
    always_comb begin
        stallf    = w_stall;
        validd    = (r_count >= CNT_W'(1));
        validd2   = (r_count >= CNT_W'(2));
        instrd    = WIDTH'(NOP_INSTR);
        instrd2   = WIDTH'(NOP_INSTR);
        pcd       = '0;
        pcd2      = '0;
        pcplus4d  = '0;
        pcplus4d2 = '0;
        if (validd) begin
            instrd   = w_rdata0[2*WIDTH-1:WIDTH];
            pcd      = w_pc0;
            pcplus4d = w_pc0 + WIDTH'(4);
        end
        if (validd2) begin
            instrd2   = w_rdata1[2*WIDTH-1:WIDTH];
            pcd2      = w_pc1;
            pcplus4d2 = w_pc1 + WIDTH'(4);
        end
    end

endmodule
